// File: rtl/sound_mailbox_pkg.sv
// Shared parameter checks, width helpers and reset values for the sound command mailbox.
package sound_mailbox_pkg;

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit clk_div_ok(input int clk_div);
        return clk_div >= 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A divide-by-one still needs a one-bit counter to keep the port widths legal.
    function automatic int div_w(input int clk_div);
        return (clk_div <= 1) ? 1 : $clog2(clk_div);
    endfunction

    localparam logic RST_IRQ        = 1'b0;
    localparam logic RST_OVERFLOW   = 1'b0;
    localparam logic RST_SND_CLK_EN = 1'b0;

endpackage

// File: rtl/sound_cmd_fifo.sv
// Fall-through command FIFO: power-of-two storage, wrapping pointers and a separate
// occupancy counter. The caller guarantees push only when there is room (or a pop).
module sound_cmd_fifo
    import sound_mailbox_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         head_o,
    output logic [count_w(DEPTH)-1:0] count_o,
    output logic                      empty_o,
    output logic                      full_o
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = count_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Storage has no reset: an empty FIFO is never read, the hold register covers that case.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sound_command_mailbox.sv
// Main-CPU to sound-CPU command mailbox with interrupt request and AY clock enable.
// Define SOUND_CMD_IRQ_EN to also raise the sound-CPU interrupt on every accepted command.
module sound_command_mailbox
    import sound_mailbox_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int CLK_DIV = 2
) (
    input  logic                      CPU_CLOCK,
    input  logic                      RESET,
    input  logic                      WR_STB,
    input  logic [DATA_W-1:0]         DB,
    input  logic                      FLUSH,
    input  logic                      RD_STB,
    output logic [DATA_W-1:0]         SD_OUT,
    output logic                      SD_OE,
    input  logic                      INT_TICK,
    input  logic                      INTACK,
    output logic                      SINT_AL,
    output logic                      EMPTY,
    output logic                      FULL,
    output logic [count_w(DEPTH)-1:0] COUNT,
    output logic                      OVERFLOW,
    output logic                      SND_CLK_EN
);

    localparam int DIV_W = div_w(CLK_DIV);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sound_command_mailbox: DEPTH must be a power of two >= 2");
    end
    if (!clk_div_ok(CLK_DIV)) begin : g_bad_div
        $error("sound_command_mailbox: CLK_DIV must be >= 1");
    end

    logic [DATA_W-1:0] head;
    logic              fifo_empty, fifo_full;
    logic              push, pop, drop, irq_set;

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              clk_en_q, clk_en_d;

    // A full FIFO still accepts a write when the same cycle pops; FLUSH discards everything.
    assign pop  = RD_STB & ~fifo_empty & ~FLUSH;
    assign push = WR_STB & ~FLUSH & (~fifo_full | pop);
    assign drop = WR_STB & fifo_full & ~RD_STB & ~FLUSH;

`ifdef SOUND_CMD_IRQ_EN
    assign irq_set = INT_TICK | push;
`else
    assign irq_set = INT_TICK;
`endif

    sound_cmd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (CPU_CLOCK),
        .srst    (RESET),
        .flush_i (FLUSH),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (DB),
        .head_o  (head),
        .count_o (COUNT),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        hold_d   = hold_q;
        ovf_d    = ovf_q;
        irq_d    = irq_q;
        div_d    = div_q + 1'b1;
        clk_en_d = 1'b0;
        if (pop) begin
            hold_d = head;
        end
        if (FLUSH) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (INTACK) begin
            irq_d = 1'b0;
        end
        // The enable is registered, so it lands one cycle after the terminal count.
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
            div_d    = '0;
            clk_en_d = 1'b1;
        end
    end

    always_ff @(posedge CPU_CLOCK) begin
        if (RESET) begin
            hold_q   <= '0;
            ovf_q    <= RST_OVERFLOW;
            irq_q    <= RST_IRQ;
            div_q    <= '0;
            clk_en_q <= RST_SND_CLK_EN;
        end else begin
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            div_q    <= div_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign SD_OUT     = fifo_empty ? hold_q : head;
    assign SD_OE      = RD_STB;
    assign SINT_AL    = ~irq_q;
    assign EMPTY      = fifo_empty;
    assign FULL       = fifo_full;
    assign OVERFLOW   = ovf_q;
    assign SND_CLK_EN = clk_en_q;

endmodule

// File: tb/tb_sound_command_mailbox.sv
// Bench for sound_command_mailbox: directed scenarios plus random traffic against a queue model.
module tb_sound_command_mailbox;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int CLK_DIV = 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
`ifdef SOUND_CMD_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, wr, fl, rd, tk, ak;
    logic [DATA_W-1:0] db;
    logic [DATA_W-1:0] sd_out;
    logic              sd_oe, sint_al, empty, full, overflow, snd_clk_en;
    logic [CNT_W-1:0]  count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_hold;
    bit                m_ovf, m_irq;
    int                m_n;

    always #5 clk = ~clk;

    sound_command_mailbox #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .CPU_CLOCK  (clk),
        .RESET      (rst),
        .WR_STB     (wr),
        .DB         (db),
        .FLUSH      (fl),
        .RD_STB     (rd),
        .SD_OUT     (sd_out),
        .SD_OE      (sd_oe),
        .INT_TICK   (tk),
        .INTACK     (ak),
        .SINT_AL    (sint_al),
        .EMPTY      (empty),
        .FULL       (full),
        .COUNT      (count),
        .OVERFLOW   (overflow),
        .SND_CLK_EN (snd_clk_en)
    );

    function automatic logic [DATA_W-1:0] m_sd();
        return (q.size() == 0) ? m_hold : q[0];
    endfunction

    function automatic bit m_en();
        return (m_n > 0) && (m_n % CLK_DIV == 0);
    endfunction

    task automatic model_edge();
        bit acc;
        acc = 1'b0;
        if (rst) begin
            q.delete();
            m_hold = '0;
            m_ovf  = 1'b0;
            m_irq  = 1'b0;
            m_n    = 0;
        end else begin
            if (fl) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (wr && q.size() == DEPTH && !rd) m_ovf = 1'b1;
                if (rd && q.size() > 0) m_hold = q.pop_front();
                if (wr && q.size() < DEPTH) begin
                    q.push_back(db);
                    acc = 1'b1;
                end
            end
            if (tk || (IRQ_EN && acc)) m_irq = 1'b1;
            else if (ak) m_irq = 1'b0;
            m_n++;
        end
    endtask

    task automatic set_in(input bit w, input logic [DATA_W-1:0] d, input bit r,
                          input bit f, input bit t, input bit a);
        rst = 1'b0; wr = w; db = d; rd = r; fl = f; tk = t; ak = a;
        #1;
    endtask

    task automatic clk_step();
        if (wr || rd)
            $display("txn t=%0t wr=%0b rd=%0b flush=%0b db=%02h sd=%02h count=%0d",
                     $time, wr, rd, fl, db, sd_out, count);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        checks++; if (sd_out !== 8'h00) begin failures++; $display("FAIL reset_sd got=%02h exp=00", sd_out); end
        checks++; if (sint_al !== 1'b1) begin failures++; $display("FAIL reset_sint got=%0b exp=1", sint_al); end
        checks++; if (snd_clk_en !== 1'b0) begin failures++; $display("FAIL reset_clken got=%0b exp=0", snd_clk_en); end
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            set_in(1, vals[i], 0, 0, 0, 0);
            clk_step();
        end
        idle();
        checks++; if (count !== CNT_W'(3)) begin failures++; $display("FAIL basic_count got=%0d exp=3", count); end
        checks++; if (sd_out !== 8'h11) begin failures++; $display("FAIL basic_fallthru got=%02h exp=11", sd_out); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h00, 1, 0, 0, 0);
            checks++; if (sd_out !== vals[i]) begin failures++; $display("FAIL basic_read%0d got=%02h exp=%02h", i, sd_out, vals[i]); end
            checks++; if (sd_oe !== 1'b1) begin failures++; $display("FAIL basic_oe got=%0b exp=1", sd_oe); end
            clk_step();
        end
        idle();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%0b exp=1", empty); end
        checks++; if (sd_oe !== 1'b0) begin failures++; $display("FAIL basic_oe_idle got=%0b exp=0", sd_oe); end
    endtask

    task automatic test_overflow();
        set_in(0, 8'h00, 0, 1, 0, 0); clk_step();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 8'hA0 + 8'(i), 0, 0, 0, 0);
            clk_step();
        end
        idle();
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%0b exp=1", full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
        checks++; if (count !== CNT_W'(4)) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'h00, 1, 0, 0, 0);
            checks++; if (sd_out !== 8'hA0 + 8'(i)) begin failures++; $display("FAIL ovf_read%0d got=%02h exp=%02h", i, sd_out, 8'hA0 + 8'(i)); end
            clk_step();
        end
        idle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
        set_in(0, 8'h00, 0, 1, 0, 0); clk_step(); idle();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_flush got=%0b exp=0", overflow); end
        checks++; if (sd_out !== 8'hA3) begin failures++; $display("FAIL ovf_hold got=%02h exp=a3", sd_out); end
    endtask

    task automatic test_full_rdwr();
        logic [DATA_W-1:0] exp_rd [4];
        for (int i = 0; i < 4; i++) begin
            set_in(1, 8'hA0 + 8'(i), 0, 0, 0, 0);
            clk_step();
        end
        set_in(1, 8'h55, 1, 0, 0, 0);
        checks++; if (sd_out !== 8'hA0) begin failures++; $display("FAIL fullrw_read got=%02h exp=a0", sd_out); end
        clk_step(); idle();
        checks++; if (count !== CNT_W'(4)) begin failures++; $display("FAIL fullrw_count got=%0d exp=4", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullrw_ovf got=%0b exp=0", overflow); end
        exp_rd[0] = 8'hA1; exp_rd[1] = 8'hA2; exp_rd[2] = 8'hA3; exp_rd[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            set_in(0, 8'h00, 1, 0, 0, 0);
            checks++; if (sd_out !== exp_rd[i]) begin failures++; $display("FAIL fullrw_drain%0d got=%02h exp=%02h", i, sd_out, exp_rd[i]); end
            clk_step();
        end
    endtask

    task automatic test_empty_read();
        set_in(1, 8'h33, 0, 0, 0, 0); clk_step();
        set_in(0, 8'h00, 1, 0, 0, 0); clk_step();
        set_in(0, 8'h00, 1, 0, 0, 0);
        checks++; if (sd_out !== 8'h33) begin failures++; $display("FAIL emptyrd_hold got=%02h exp=33", sd_out); end
        clk_step(); idle();
        checks++; if (count !== '0) begin failures++; $display("FAIL emptyrd_count got=%0d exp=0", count); end
        set_in(1, 8'h44, 1, 0, 0, 0);
        checks++; if (sd_out !== 8'h33) begin failures++; $display("FAIL emptyrw_read got=%02h exp=33", sd_out); end
        clk_step(); idle();
        checks++; if (count !== CNT_W'(1)) begin failures++; $display("FAIL emptyrw_count got=%0d exp=1", count); end
        checks++; if (sd_out !== 8'h44) begin failures++; $display("FAIL emptyrw_head got=%02h exp=44", sd_out); end
        set_in(0, 8'h00, 1, 0, 0, 0); clk_step(); idle();
    endtask

    task automatic test_irq();
        set_in(0, 8'h00, 0, 0, 0, 1); clk_step(); idle();
        checks++; if (sint_al !== 1'b1) begin failures++; $display("FAIL irq_idle got=%0b exp=1", sint_al); end
        set_in(0, 8'h00, 0, 0, 1, 0); clk_step(); idle();
        checks++; if (sint_al !== 1'b0) begin failures++; $display("FAIL irq_tick got=%0b exp=0", sint_al); end
        set_in(0, 8'h00, 0, 0, 1, 1); clk_step(); idle();
        checks++; if (sint_al !== 1'b0) begin failures++; $display("FAIL irq_tick_ack got=%0b exp=0", sint_al); end
        set_in(0, 8'h00, 0, 0, 0, 1); clk_step(); idle();
        checks++; if (sint_al !== 1'b1) begin failures++; $display("FAIL irq_ack got=%0b exp=1", sint_al); end
        set_in(1, 8'h77, 0, 0, 0, 0); clk_step(); idle();
        checks++; if (sint_al !== !IRQ_EN) begin failures++; $display("FAIL irq_on_write got=%0b exp=%0b", sint_al, !IRQ_EN); end
        set_in(0, 8'h00, 1, 0, 0, 1); clk_step(); idle();
    endtask

    task automatic test_divider();
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            clk_step();
            checks++; if (snd_clk_en !== (k % CLK_DIV == 0)) begin failures++; $display("FAIL div_cycle%0d got=%0b exp=%0b", k, snd_clk_en, (k % CLK_DIV == 0)); end
        end
        set_in(1, 8'h5A, 0, 0, 1, 0); clk_step();
        set_in(1, 8'h5B, 0, 0, 0, 0); clk_step();
        clk_step();
        do_reset();
        checks++; if (count !== '0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midrst_empty got=%0b exp=1", empty); end
        checks++; if (sint_al !== 1'b1) begin failures++; $display("FAIL midrst_sint got=%0b exp=1", sint_al); end
        checks++; if (snd_clk_en !== 1'b0) begin failures++; $display("FAIL midrst_clken got=%0b exp=0", snd_clk_en); end
        for (int k = 1; k <= 4; k++) begin
            clk_step();
            checks++; if (snd_clk_en !== (k % CLK_DIV == 0)) begin failures++; $display("FAIL div_restart%0d got=%0b exp=%0b", k, snd_clk_en, (k % CLK_DIV == 0)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(1, 0) == 1,
                   $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0,
                   $urandom_range(7, 0) == 0);
            rst = ($urandom_range(63, 0) == 0);
            #1;
            checks++; if (sd_out !== m_sd()) begin failures++; $display("FAIL rnd_sd i=%0d got=%02h exp=%02h", i, sd_out, m_sd()); end
            checks++; if (sd_oe !== rd) begin failures++; $display("FAIL rnd_oe i=%0d got=%0b exp=%0b", i, sd_oe, rd); end
            checks++; if (count !== CNT_W'(q.size())) begin failures++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, q.size()); end
            checks++; if (empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty i=%0d got=%0b exp=%0b", i, empty, q.size() == 0); end
            checks++; if (full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full i=%0d got=%0b exp=%0b", i, full, q.size() == DEPTH); end
            checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf i=%0d got=%0b exp=%0b", i, overflow, m_ovf); end
            checks++; if (sint_al !== !m_irq) begin failures++; $display("FAIL rnd_sint i=%0d got=%0b exp=%0b", i, sint_al, !m_irq); end
            checks++; if (snd_clk_en !== m_en()) begin failures++; $display("FAIL rnd_clken i=%0d got=%0b exp=%0b", i, snd_clk_en, m_en()); end
            clk_step();
        end
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; db = '0; rd = 1'b0; fl = 1'b0; tk = 1'b0; ak = 1'b0;
        m_hold = '0; m_ovf = 1'b0; m_irq = 1'b0; m_n = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_rdwr();
        test_empty_read();
        test_irq();
        test_divider();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
